// File: rtl/alu.sv
// 4-bit arithmetic/logic unit: sixteen operations selected by F, result registered into D.
// Only Cin[0] takes part in ADD, SUB, SHL and SHR; every other operation ignores Cin.
module alu (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic [3:0] Cin,
   input  logic [3:0] F,
   output logic [3:0] D
);

   logic       c;
   logic [3:0] c_ext;
   logic [3:0] result;
   logic       unused_cin;

   assign c          = Cin[0];
   assign c_ext      = {3'b000, Cin[0]};
   assign unused_cin = ^Cin[3:1];

   // Carry and borrow out of bit 3 are dropped by keeping every sum at 4 bits.
   always_comb begin
      result = 4'b0000;
      case (F)
         4'd0:  result = A + B + c_ext;
         4'd1:  result = A - B - c_ext;
         4'd2:  result = A + 4'd1;
         4'd3:  result = A - 4'd1;
         4'd4:  result = A & B;
         4'd5:  result = A | B;
         4'd6:  result = A ^ B;
         4'd7:  result = ~(A & B);
         4'd8:  result = ~(A | B);
         4'd9:  result = ~(A ^ B);
         4'd10: result = ~A;
         4'd11: result = {A[2:0], c};
         4'd12: result = {c, A[3:1]};
         4'd13: result = {A[2:0], A[3]};
         4'd14: result = {A[0], A[3:1]};
         4'd15: result = {3'b000, (A < B)};
         default: result = 4'b0000;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) D <= 4'b0000;
      else        D <= result;
   end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed plan steps plus randomized operations
// compared against an arithmetic reference model.
module tb_alu;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] a = 4'd0;
   logic [3:0] b = 4'd0;
   logic [3:0] cin = 4'd0;
   logic [3:0] f = 4'd0;
   logic [3:0] d;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   alu dut (
      .clk  (clk),
      .rst_n(rst_n),
      .A    (a),
      .B    (b),
      .Cin  (cin),
      .F    (f),
      .D    (d)
   );

   always #5 clk = ~clk;

   // Reference model: plain integer arithmetic, everything reduced modulo 16.
   function automatic logic [3:0] model(input int av, input int bv, input int cv, input int fv);
      int c;
      int r;
      c = cv % 2;
      case (fv)
         0:  r = (av + bv + c) % 16;
         1:  r = (av - bv - c + 32) % 16;
         2:  r = (av + 1) % 16;
         3:  r = (av + 15) % 16;
         4:  r = av & bv;
         5:  r = av | bv;
         6:  r = av ^ bv;
         7:  r = 15 - (av & bv);
         8:  r = 15 - (av | bv);
         9:  r = 15 - (av ^ bv);
         10: r = 15 - av;
         11: r = (av * 2 + c) % 16;
         12: r = av / 2 + 8 * c;
         13: r = (av * 2) % 16 + av / 8;
         14: r = av / 2 + 8 * (av % 2);
         default: r = (av < bv) ? 1 : 0;
      endcase
      return r[3:0];
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Drive on the falling edge, sample 1 ns after the next rising edge.
   task automatic drive(input logic [3:0] av, input logic [3:0] bv, input logic [3:0] cv, input logic [3:0] fv);
      @(negedge clk);
      a = av; b = bv; cin = cv; f = fv;
      @(posedge clk);
      #1;
   endtask

   task automatic directed(input string tag, input logic [3:0] av, input logic [3:0] bv,
                           input logic [3:0] cv, input logic [3:0] fv, input logic [3:0] exp);
      drive(av, bv, cv, fv);
      check(tag, d, exp);
   endtask

   task automatic modeled(input string tag, input logic [3:0] av, input logic [3:0] bv,
                          input logic [3:0] cv, input logic [3:0] fv);
      drive(av, bv, cv, fv);
      check(tag, d, model(int'(av), int'(bv), int'(cv), int'(fv)));
   endtask

   logic [3:0] logic_exp [0:6];
   logic [3:0] shift_exp [0:3];
   logic [3:0] held;

   initial begin
      logic_exp = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0011};
      shift_exp = '{4'b0010, 4'b0100, 4'b0011, 4'b1100};

      // Asynchronous reset before any rising edge has occurred.
      a = 4'd5; b = 4'd3; cin = 4'd0; f = 4'd0;
      #2 rst_n = 1'b0;
      #1 check("reset_async", d, 4'b0000);
      @(posedge clk); #1;
      check("reset_hold", d, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset_release", d, 4'b1000);

      // Arithmetic and boundaries
      directed("add_carry", 4'b0111, 4'b0001, 4'b0001, 4'd0, 4'b1001);
      directed("add_wrap",  4'b1111, 4'b0001, 4'b0000, 4'd0, 4'b0000);
      directed("sub_wrap",  4'b0000, 4'b0001, 4'b0000, 4'd1, 4'b1111);
      directed("sub_borrow",4'b0000, 4'b0001, 4'b0001, 4'd1, 4'b1110);
      directed("inc_wrap",  4'b1111, 4'b0000, 4'b0000, 4'd2, 4'b0000);
      directed("dec_wrap",  4'b0000, 4'b0000, 4'b0000, 4'd3, 4'b1111);
      directed("add_hi_cin",4'b0011, 4'b0100, 4'b1110, 4'd0, 4'b0111);

      // Logic ops, then again with upper Cin bits set
      for (int i = 0; i < 7; i++)
         directed($sformatf("logic_f%0d", i + 4), 4'b1100, 4'b1010, 4'b0000, 4'(i + 4), logic_exp[i]);
      for (int i = 0; i < 7; i++)
         directed($sformatf("logic_cin_f%0d", i + 4), 4'b1100, 4'b1010, 4'b1110, 4'(i + 4), logic_exp[i]);

      // Shifts and rotates
      for (int i = 0; i < 4; i++)
         directed($sformatf("shift_f%0d", i + 11), 4'b1001, 4'b0000, 4'b0000, 4'(i + 11), shift_exp[i]);
      directed("shl_c1", 4'b1001, 4'b0000, 4'b0001, 4'd11, 4'b0011);
      directed("shr_c1", 4'b1001, 4'b0000, 4'b0001, 4'd12, 4'b1100);
      directed("rol_cin", 4'b1001, 4'b0000, 4'b1111, 4'd13, 4'b0011);

      // Compare
      directed("sltu_lt", 4'b0010, 4'b0011, 4'b0000, 4'd15, 4'b0001);
      directed("sltu_ge", 4'b0011, 4'b0010, 4'b0000, 4'd15, 4'b0000);
      directed("sltu_eq", 4'b0110, 4'b0110, 4'b0001, 4'd15, 4'b0000);

      // Inputs changing between edges must not reach D.
      directed("latency_base", 4'b0101, 4'b0011, 4'b0000, 4'd0, 4'b1000);
      held = d;
      #2 a = 4'b1111; f = 4'd6;
      #2 b = 4'b0001; cin = 4'b0001; f = 4'd1;
      #1 check("latency_hold", d, held);
      @(negedge clk);
      a = 4'b0100; b = 4'b0001; cin = 4'b0000; f = 4'd3;
      #2 a = 4'b1010;
      @(posedge clk); #1;
      check("latency_next", d, 4'b1001);

      // Back-to-back sweep with a mid-cycle reset pulse.
      for (int i = 0; i < 16; i++) begin
         logic [3:0] ra, rb, rc;
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         rc = 4'($urandom_range(0, 15));
         modeled($sformatf("sweep_f%0d", i), ra, rb, rc, 4'(i));
         if (i == 8) begin
            #2 rst_n = 1'b0;
            #1 check("midreset_async", d, 4'b0000);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk); #1;
            check("midreset_resume", d, model(int'(ra), int'(rb), int'(rc), i));
         end
      end

      // Randomized operations against the model.
      for (int i = 0; i < 200; i++)
         modeled("random", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
